// File: rtl/burst_period_pkg.sv
// Shared types and constants for the burst-period generator.
// Holds the mode encodings, FSM state type and default widths.
package burst_period_pkg;

  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [1:0] MODE_CONT  = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_GATE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Mode 3 is reserved and behaves as continuous.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_CONT : mode;
  endfunction

endpackage

// File: rtl/burst_phase_acc.sv
// Phase accumulator: registered increment, ACC_W accumulator with clear/enable,
// registered carry pulse. Exposes the carry of the pending add for the controller.
module burst_phase_acc
  import burst_period_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ACC_W-1:0]  Period_in,
  input  logic              clear,
  input  logic              enable,
  output logic              carry_next,
  output logic [ADDR_W-1:0] phase,
  output logic              PCO
);

  logic [ACC_W-1:0] period_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;
  logic             pco_q;

  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, period_q};
    carry_next = sum[ACC_W];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      period_q <= '0;
    end else begin
      period_q <= Period_in;
    end
  end

  // Clear beats enable so a completing carry still pulses PCO but leaves acc at 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q <= '0;
      pco_q <= 1'b0;
    end else begin
      pco_q <= enable & carry_next;
      if (clear) begin
        acc_q <= '0;
      end else if (enable) begin
        acc_q <= sum[ACC_W-1:0];
      end
    end
  end

  assign phase = acc_q[ACC_W-1 -: ADDR_W];
  assign PCO   = pco_q;

endmodule

// File: rtl/burst_period_gen.sv
// Burst-period generator: run-mode FSM, burst counter, duty compare and output registers.
// Define BURST_PERIOD_GEN_TRIG_SYNC_EN to pass Trig through a 2-flop synchroniser.
module burst_period_gen
  import burst_period_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ACC_W-1:0]  Period_in,
  input  logic [ADDR_W-1:0] Duty_in,
  input  logic [CNT_W-1:0]  Burst_Cnt_in,
  input  logic [1:0]        Mode_in,
  input  logic              Trig,
  input  logic              Burst_EN,
  output logic              Period_Ctrl,
  output logic              PCO,
  output logic              Busy,
  output logic              Done
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              trig_s;
  logic              trig_d_q;
  logic              trig_rise;
  logic              carry_next;
  logic [ADDR_W-1:0] phase;
  logic [ADDR_W-1:0] phase_q;
  logic              phase_vld_q;
  logic              ctrl_q;
  logic              acc_clear;
  logic              acc_enable;

`ifdef BURST_PERIOD_GEN_TRIG_SYNC_EN
  logic [1:0] trig_sync_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      trig_sync_q <= '0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], Trig};
    end
  end

  assign trig_s = trig_sync_q[1];
`else
  assign trig_s = Trig;
`endif

  assign trig_rise = trig_s & ~trig_d_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Burst_EN) begin
          unique case (norm_mode(Mode_in))
            MODE_BURST: begin
              if (trig_rise && (Burst_Cnt_in != '0)) begin
                state_d = RUN;
                mode_d  = MODE_BURST;
                cnt_d   = Burst_Cnt_in;
              end
            end
            MODE_GATE: begin
              if (trig_s) begin
                state_d = RUN;
                mode_d  = MODE_GATE;
              end
            end
            default: begin
              state_d = RUN;
              mode_d  = MODE_CONT;
            end
          endcase
        end
      end
      RUN: begin
        if ((mode_q == MODE_BURST) && carry_next) begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if ((mode_q == MODE_GATE) && !trig_s) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A carry finishes the drain even if the gate re-asserts on the same cycle.
        if (carry_next) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (trig_s) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!Burst_EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_CONT;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      trig_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      trig_d_q <= trig_s;
    end
  end

  assign acc_enable = (state_q != IDLE) && Burst_EN;
  assign acc_clear  = (state_q == IDLE) || !Burst_EN || done_d;

  burst_phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_phase_acc (
    .Clock      (Clock),
    .Reset      (Reset),
    .Period_in  (Period_in),
    .clear      (acc_clear),
    .enable     (acc_enable),
    .carry_next (carry_next),
    .phase      (phase),
    .PCO        (PCO)
  );

  // Two-stage duty pipeline; the valid bit forces Period_Ctrl low two cycles into IDLE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      ctrl_q      <= 1'b0;
    end else begin
      phase_vld_q <= (state_q != IDLE);
      phase_q     <= (state_q != IDLE) ? phase : '0;
      ctrl_q      <= phase_vld_q && (phase_q < Duty_in);
    end
  end

  assign Period_Ctrl = ctrl_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;

endmodule

// File: tb/tb_burst_period_gen.sv
// Directed bench for burst_period_gen: vector table for continuous mode and reset,
// hand-written sequences for burst, gate, abort and duty corner cases.
module tb_burst_period_gen;

  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 8;
`ifdef BURST_PERIOD_GEN_TRIG_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [ACC_W-1:0]  Period_in = 16'h4000;
  logic [ADDR_W-1:0] Duty_in = 4'd8;
  logic [CNT_W-1:0]  Burst_Cnt_in = 8'd0;
  logic [1:0]        Mode_in = 2'd0;
  logic              Trig = 1'b0;
  logic              Burst_EN = 1'b0;
  logic              Period_Ctrl;
  logic              PCO;
  logic              Busy;
  logic              Done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  burst_period_gen #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Period_in    (Period_in),
    .Duty_in      (Duty_in),
    .Burst_Cnt_in (Burst_Cnt_in),
    .Mode_in      (Mode_in),
    .Trig         (Trig),
    .Burst_EN     (Burst_EN),
    .Period_Ctrl  (Period_Ctrl),
    .PCO          (PCO),
    .Busy         (Busy),
    .Done         (Done)
  );

  typedef struct {
    logic rst;
    logic en;
    logic ctrl;
    logic pco;
    logic busy;
    logic done;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic setup(input logic [1:0] mode, input logic [15:0] period, input logic [3:0] duty,
                       input logic [7:0] cnt);
    Mode_in      = mode;
    Period_in    = period;
    Duty_in      = duty;
    Burst_Cnt_in = cnt;
    Burst_EN     = 1'b0;
    Trig         = 1'b0;
    repeat (4) tick();
  endtask

  // Bit i of each mask is the input driven for / output expected after edge i.
  task automatic run(input string name, input int n, input logic [63:0] trig_mask,
                     input logic [63:0] en_mask, input logic [63:0] exp_pco,
                     input logic [63:0] exp_done, input logic [63:0] exp_busy);
    for (int i = 0; i < n; i++) begin
      Trig     = trig_mask[i];
      Burst_EN = en_mask[i];
      tick();
      check({name, "_pco"}, i, PCO, exp_pco[i]);
      check({name, "_done"}, i, Done, exp_done[i]);
      check({name, "_busy"}, i, Busy, exp_busy[i]);
    end
    Trig = 1'b0;
  endtask

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONE = 64'd1;

  initial begin
    // Mode 0, Period 0x4000, Duty 8, with a reset in the middle of the run.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      Reset    = vecs[i].rst;
      Burst_EN = vecs[i].en;
      tick();
      check("cont_ctrl", i, Period_Ctrl, vecs[i].ctrl);
      check("cont_pco", i, PCO, vecs[i].pco);
      check("cont_busy", i, Busy, vecs[i].busy);
      check("cont_done", i, Done, vecs[i].done);
    end
    Reset = 1'b0;

    // Burst of 3 with an ignored retrigger at cycle 6.
    setup(2'd1, 16'h4000, 4'd8, 8'd3);
    run("burst3", 20, 64'h41, ALL,
        (ONE << (4 + L)) | (ONE << (8 + L)) | (ONE << (12 + L)),
        ONE << (12 + L), ((ONE << 12) - ONE) << L);

    // Gate high for 6 cycles, then drain to the end of the period.
    setup(2'd2, 16'h4000, 4'd8, 8'd0);
    run("gate", 16, 64'h3F, ALL,
        (ONE << (4 + L)) | (ONE << (8 + L)), ONE << (8 + L), ((ONE << 8) - ONE) << L);

    // Enable dropped right after the first carry aborts without Done.
    setup(2'd1, 16'h4000, 4'd8, 8'd3);
    run("abort", 20, 64'h1, (ONE << (5 + L)) - ONE,
        ONE << (4 + L), 64'd0, ((ONE << 5) - ONE) << L);

    // Zero burst count never starts.
    setup(2'd1, 16'h4000, 4'd8, 8'd0);
    run("cnt0", 10, 64'h1, ALL, 64'd0, 64'd0, 64'd0);

    // Single-period burst; start latency includes the synchroniser when built in.
    setup(2'd1, 16'h4000, 4'd8, 8'd1);
    run("cnt1", 10, 64'h1, ALL, ONE << (4 + L), ONE << (4 + L), ((ONE << 4) - ONE) << L);

    // Reserved mode 3 starts immediately like continuous.
    setup(2'd3, 16'h4000, 4'd8, 8'd0);
    run("mode3", 3, 64'h0, ALL, 64'd0, 64'd0, 64'h7);

    // Duty at maximum: low only at phase 15, two-cycle lag after start.
    setup(2'd0, 16'h1000, 4'd15, 8'd0);
    Burst_EN = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      check("duty_max", i, Period_Ctrl, (i >= 2) && (((i - 2) % 16) != 15));
    end

    // Duty zero: always low.
    Duty_in = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("duty_zero", i, Period_Ctrl, 1'b0);
    end
    Burst_EN = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
